// File: rtl/round_key_store.sv
// round_key_store
//   Round-key buffer behind the key-expansion stage. Captures one 128-bit
//   round key per valid beat into an indexed store (11 keys for AES-128,
//   15 for AES-256) and serves them through a registered random-access
//   read port, including while the fill is still in progress.
//
//   Optional feature macro: RKS_DECRYPT_EN
//     defined   : rd_dir=1 reads entry LAST - rd_idx (reverse / decrypt order)
//     undefined : rd_dir is ignored, every read is forward
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   keyLen     0 = AES-128 (LAST=10), 1 = AES-256 (LAST=14); sampled on start
//   start      one-cycle pulse, begins a new fill
//   key_valid  key_in holds a round key this cycle
//   key_in     round key, round 0 first
//   rd_req     read request
//   rd_idx     requested round index
//   rd_dir     0 = forward, 1 = reverse index (RKS_DECRYPT_EN only)
//   rd_key     read data, 1 cycle after rd_req (0 on error)
//   rd_valid   rd_key/rd_err valid this cycle
//   rd_err     read was illegal
//   ready      all keys for the latched keyLen are stored
//   fill_cnt   entries written since start
//   ovf        sticky: a key arrived when none was expected
module round_key_store #(
  parameter int KEY_WIDTH = 128,
  parameter int DEPTH     = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 keyLen,
  input  logic                 start,
  input  logic                 key_valid,
  input  logic [KEY_WIDTH-1:0] key_in,
  input  logic                 rd_req,
  input  logic [3:0]           rd_idx,
  input  logic                 rd_dir,
  output logic [KEY_WIDTH-1:0] rd_key,
  output logic                 rd_valid,
  output logic                 rd_err,
  output logic                 ready,
  output logic [3:0]           fill_cnt,
  output logic                 ovf
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_READY = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic                 key_len_q;
  logic [3:0]           last;
  logic                 wr_en;
  logic [3:0]           eff_idx;
  logic                 rd_legal;
  logic [KEY_WIDTH-1:0] mem [DEPTH];

  assign last = key_len_q ? 4'd14 : 4'd10;

  // A key coinciding with start belongs to no fill: it neither writes nor
  // counts as an overflow.
  assign wr_en = (state_q == S_FILL) && key_valid && !start;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start)
      state_d = S_FILL;
    else if (wr_en && (fill_cnt == last))
      state_d = S_READY;
  end

  assign ready = (state_q == S_READY);

  // ------------------------------------------------------- fill control
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_len_q <= 1'b0;
      fill_cnt  <= 4'd0;
      ovf       <= 1'b0;
    end else if (start) begin
      key_len_q <= keyLen;
      fill_cnt  <= 4'd0;
      ovf       <= 1'b0;
    end else begin
      if (wr_en)
        fill_cnt <= fill_cnt + 4'd1;
      if (key_valid && (state_q != S_FILL))
        ovf <= 1'b1;
    end
  end

  // Storage carries no reset; an entry is only readable once fill_cnt has
  // moved past it, so stale contents never reach rd_key.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[fill_cnt] <= key_in;
  end

  // --------------------------------------------------------- read port
`ifdef RKS_DECRYPT_EN
  always_comb begin
    eff_idx = rd_idx;
    if (rd_dir)
      eff_idx = last - rd_idx;
  end
`else
  logic unused_rd_dir;
  assign unused_rd_dir = rd_dir;
  assign eff_idx       = rd_idx;
`endif

  // Range check uses rd_idx so the 4-bit reverse subtraction can never wrap
  // into a legal-looking index. Comparing against the pre-write fill_cnt
  // makes a same-cycle write+read of one entry error out, and a read in the
  // start cycle sees the cleared count and errors as well.
  assign rd_legal = !start && (state_q != S_IDLE) &&
                    (rd_idx <= last) && (eff_idx < fill_cnt);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
      rd_key   <= '0;
    end else begin
      rd_valid <= rd_req;
      rd_err   <= rd_req && !rd_legal;
      rd_key   <= (rd_req && rd_legal) ? mem[eff_idx] : '0;
    end
  end

endmodule

// File: tb/tb_round_key_store.sv
// Directed bench for round_key_store: AES-128 fill with the FIPS-197 key
// schedule of 000102..0f, partial-fill reads, overflow/restart, AES-256
// fill with range errors, and reset mid-fill.
module tb_round_key_store;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         keyLen = 1'b0;
  logic         start = 1'b0;
  logic         key_valid = 1'b0;
  logic [127:0] key_in = '0;
  logic         rd_req = 1'b0;
  logic [3:0]   rd_idx = '0;
  logic         rd_dir = 1'b0;
  logic [127:0] rd_key;
  logic         rd_valid;
  logic         rd_err;
  logic         ready;
  logic [3:0]   fill_cnt;
  logic         ovf;

  logic [127:0] k128 [11];
  logic [127:0] k256 [15];
  logic [127:0] exp_rev;
  int n_cmp = 0;
  int n_err = 0;

  round_key_store #(.KEY_WIDTH(128), .DEPTH(15)) dut (
    .clk(clk), .reset(reset), .keyLen(keyLen), .start(start),
    .key_valid(key_valid), .key_in(key_in), .rd_req(rd_req),
    .rd_idx(rd_idx), .rd_dir(rd_dir), .rd_key(rd_key),
    .rd_valid(rd_valid), .rd_err(rd_err), .ready(ready),
    .fill_cnt(fill_cnt), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    k128[0]  = 128'h000102030405060708090a0b0c0d0e0f;
    k128[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    k128[2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
    k128[3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
    k128[4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
    k128[5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
    k128[6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
    k128[7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
    k128[8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
    k128[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
    k128[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    for (int i = 0; i < 15; i++)
      k256[i] = {4{32'hA5C30000 + 32'(i)}};

    // ---- reset state (async, before any clock edge)
    #3;
    chk("rst_rd_key",   rd_key,   128'd0);
    chk("rst_rd_valid", 128'(rd_valid), 128'd0);
    chk("rst_rd_err",   128'(rd_err),   128'd0);
    chk("rst_ready",    128'(ready),    128'd0);
    chk("rst_fill_cnt", 128'(fill_cnt), 128'd0);
    chk("rst_ovf",      128'(ovf),      128'd0);
    tick(); tick();
    reset = 1'b1;
    tick();

    // ---- IDLE: stray key sets ovf, reads error
    key_valid = 1'b1; key_in = k128[0]; rd_req = 1'b1; rd_idx = 4'd0;
    tick();
    chk("idle_ovf",      128'(ovf),      128'd1);
    chk("idle_fill",     128'(fill_cnt), 128'd0);
    chk("idle_rd_valid", 128'(rd_valid), 128'd1);
    chk("idle_rd_err",   128'(rd_err),   128'd1);
    chk("idle_rd_key",   rd_key,         128'd0);
    key_valid = 1'b0; rd_req = 1'b0;
    tick();
    chk("noreq_rd_valid", 128'(rd_valid), 128'd0);

    // ---- start with simultaneous key_valid and read
    start = 1'b1; keyLen = 1'b0; key_valid = 1'b1; key_in = '1;
    rd_req = 1'b1; rd_idx = 4'd0;
    tick();
    chk("start_ovf",    128'(ovf),      128'd0);
    chk("start_fill",   128'(fill_cnt), 128'd0);
    chk("start_ready",  128'(ready),    128'd0);
    chk("start_rd_err", 128'(rd_err),   128'd1);
    start = 1'b0; key_valid = 1'b0; rd_req = 1'b0;

    // ---- partial fill: 3 keys
    for (int i = 0; i < 3; i++) begin
      key_valid = 1'b1; key_in = k128[i];
      tick();
    end
    key_valid = 1'b0;
    chk("part_fill3", 128'(fill_cnt), 128'd3);
    rd_req = 1'b1; rd_idx = 4'd2;
    tick();
    chk("part_idx2_key", rd_key,       k128[2]);
    chk("part_idx2_err", 128'(rd_err), 128'd0);
    rd_idx = 4'd3;
    tick();
    chk("part_idx3_err", 128'(rd_err), 128'd1);
    chk("part_idx3_key", rd_key,       128'd0);
    key_valid = 1'b1; key_in = k128[3]; rd_idx = 4'd3;
    tick();
    chk("wr_rd_same_err", 128'(rd_err),   128'd1);
    chk("wr_rd_same_fill", 128'(fill_cnt), 128'd4);
    rd_req = 1'b0;

    // ---- complete AES-128 fill
    for (int i = 4; i < 10; i++) begin
      key_in = k128[i];
      tick();
    end
    chk("a128_ready_pre", 128'(ready), 128'd0);
    key_in = k128[10];
    tick();
    key_valid = 1'b0;
    chk("a128_ready", 128'(ready),    128'd1);
    chk("a128_fill",  128'(fill_cnt), 128'd11);

    rd_req = 1'b1; rd_idx = 4'd10;
    tick();
    chk("a128_idx10_key", rd_key,       k128[10]);
    chk("a128_idx10_err", 128'(rd_err), 128'd0);
    rd_idx = 4'd0;
    tick();
    chk("a128_idx0_key", rd_key, k128[0]);
    rd_idx = 4'd5;
    tick();
    chk("a128_idx5_key", rd_key, k128[5]);
    rd_idx = 4'd11;
    tick();
    chk("a128_idx11_err", 128'(rd_err), 128'd1);
    chk("a128_idx11_key", rd_key,       128'd0);
    rd_dir = 1'b1; rd_idx = 4'd0;
`ifdef RKS_DECRYPT_EN
    exp_rev = k128[10];
`else
    exp_rev = k128[0];
`endif
    tick();
    chk("rev_idx0_key", rd_key,       exp_rev);
    chk("rev_idx0_err", 128'(rd_err), 128'd0);
    rd_idx = 4'd11;
    tick();
    chk("rev_idx11_err", 128'(rd_err), 128'd1);
    rd_dir = 1'b0; rd_req = 1'b0;

    // ---- overflow after READY
    key_valid = 1'b1; key_in = '1;
    tick();
    key_valid = 1'b0;
    chk("ovf_set",  128'(ovf),      128'd1);
    chk("ovf_fill", 128'(fill_cnt), 128'd11);
    rd_req = 1'b1; rd_idx = 4'd10;
    tick();
    rd_req = 1'b0;
    chk("ovf_frozen", rd_key, k128[10]);

    // ---- restart as AES-256 with a key in the start cycle
    start = 1'b1; keyLen = 1'b1; key_valid = 1'b1; key_in = '1;
    tick();
    start = 1'b0;
    chk("rst256_ovf",   128'(ovf),      128'd0);
    chk("rst256_fill",  128'(fill_cnt), 128'd0);
    chk("rst256_ready", 128'(ready),    128'd0);
    for (int i = 0; i < 14; i++) begin
      key_in = k256[i];
      tick();
    end
    chk("a256_ready_pre", 128'(ready), 128'd0);
    key_in = k256[14];
    tick();
    key_valid = 1'b0;
    chk("a256_ready", 128'(ready),    128'd1);
    chk("a256_fill",  128'(fill_cnt), 128'd15);
    rd_req = 1'b1; rd_idx = 4'd14;
    tick();
    chk("a256_idx14_key", rd_key,       k256[14]);
    chk("a256_idx14_err", 128'(rd_err), 128'd0);
    rd_idx = 4'd15;
    tick();
    chk("a256_idx15_err", 128'(rd_err), 128'd1);
    chk("a256_idx15_key", rd_key,       128'd0);
    rd_idx = 4'd0;
    tick();
    chk("a256_idx0_key", rd_key, k256[0]);
    rd_req = 1'b0;

    // ---- reset mid-fill
    start = 1'b1; keyLen = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      key_valid = 1'b1; key_in = k128[i];
      tick();
    end
    key_valid = 1'b0; rd_req = 1'b1; rd_idx = 4'd0;
    tick();
    rd_req = 1'b0;
    chk("mid_fill5",   128'(fill_cnt), 128'd5);
    chk("mid_rd_key",  rd_key,         k128[0]);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_rd_key",   rd_key,         128'd0);
    chk("mid_rst_rd_valid", 128'(rd_valid), 128'd0);
    chk("mid_rst_fill",     128'(fill_cnt), 128'd0);
    chk("mid_rst_ready",    128'(ready),    128'd0);
    chk("mid_rst_ovf",      128'(ovf),      128'd0);
    #1 reset = 1'b1;
    tick();
    rd_req = 1'b1; rd_idx = 4'd0;
    tick();
    rd_req = 1'b0;
    chk("post_rst_rd_err", 128'(rd_err), 128'd1);
    chk("post_rst_rd_key", rd_key,       128'd0);
    key_valid = 1'b1; key_in = k128[5];
    tick();
    key_valid = 1'b0;
    chk("post_rst_ovf",  128'(ovf),      128'd1);
    chk("post_rst_fill", 128'(fill_cnt), 128'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/round_key_store.md
# round_key_store

Round-key buffer sitting directly downstream of the key-expansion stage. It captures the 128-bit round keys the expander emits, one per valid beat, into an indexed store of 11 (AES-128) or 15 (AES-256) entries. It serves them to the cipher round datapath through a registered random-access read port, including while the fill is still in progress.

## Interface
- KEY_WIDTH, 128: width of one stored round key.
- DEPTH, 15: number of entries; sized for AES-256.
- clk  in  1: rising-edge clock.
- reset  in  1: asynchronous, active-low reset.
- keyLen  in  1: 0 = AES-128 (11 keys), 1 = AES-256 (15 keys); sampled only on start.
- start  in  1: one-cycle pulse that begins a new fill.
- key_valid  in  1: key_in is a valid round key this cycle.
- key_in  in  128: round key, in round order; round 0 (cipher key or its first half) comes first.
- rd_req  in  1: read request.
- rd_idx  in  4: round index requested.
- rd_dir  in  1: 0 = forward index, 1 = reverse (decrypt) index; honoured only with RKS_DECRYPT_EN.
- rd_key  out  128: read data.
- rd_valid  out  1: rd_key/rd_err valid this cycle.
- rd_err  out  1: read was illegal; rd_key forced to 0.
- ready  out  1: all keys for the current keyLen are stored.
- fill_cnt  out  4: number of entries written since start.
- ovf  out  1: sticky; a key arrived when none was expected.

## Operation
- State machine, IDLE -> FILL -> READY; start from any state -> FILL.
- Latched keyLen sets LAST: 10 for AES-128, 14 for AES-256.
- IDLE behaviour:
  - Entered at reset.
  - key_valid sets ovf and is dropped.
  - All reads error.
- FILL behaviour:
  - Each key_valid writes key_in to mem[fill_cnt], then fill_cnt increments.
  - A write with fill_cnt == LAST moves to READY.
- READY behaviour:
  - Store is frozen.
  - key_valid sets ovf and is dropped; fill_cnt holds.
- start behaviour:
  - Clears fill_cnt, ready and ovf, and latches keyLen.
  - key_valid in the same cycle as start is ignored; it does not write and does not set ovf.
- Read address:
  - Effective index e = rd_idx, or LAST - rd_idx when rd_dir=1 and RKS_DECRYPT_EN is defined.
  - Reverse mapping uses 4-bit arithmetic and is checked for range before subtraction: rd_idx > LAST is an error.
- Read legality:
  - A read is legal iff rd_idx <= LAST and e < fill_cnt.
  - Reads during FILL are therefore legal for entries already written.
  - A legal read returns mem[e] with rd_err=0.
  - An illegal read returns rd_key=0 with rd_err=1.
- Same-cycle write and read of the same index: the read returns the old contents, so it is illegal (e == fill_cnt) and errors.
- Memory is not reset. Unwritten entries are never observable, because such reads always error.

## Timing
- Reset values: rd_key=0, rd_valid=0, rd_err=0, ready=0, fill_cnt=0, ovf=0; state IDLE, latched keyLen 0.
- Reset asserted mid-fill returns to IDLE immediately; the next fill needs a new start.
- Write latency:
  - Key accepted at edge N gives fill_cnt+1 visible after N.
  - The final key at edge N gives ready=1 after N.
- Read latency 1 cycle: rd_req at edge N gives rd_valid/rd_key/rd_err after N, for one cycle only. rd_valid=0 in cycles with no request.
- Back-to-back reads every cycle are supported; no backpressure on either port.
- start at edge N gives ready=0, fill_cnt=0, ovf=0 after N. A read issued in the start cycle is evaluated against the post-start state and errors.

## Configuration
- RKS_DECRYPT_EN:
  - Defined: rd_dir=1 selects reverse indexing (LAST - rd_idx), so decryption can issue round counts 0..LAST directly.
  - Undefined: rd_dir is ignored and all reads are forward. The port remains for interface stability.

## Test plan
- AES-128 fill:
  - Stimulus: start with keyLen=0, then 11 expanded keys of cipher key 000102030405060708090a0b0c0d0e0f.
  - Required: ready=1 after the 11th write, fill_cnt=11; read idx 10 returns 13111d7fe3944a17f307a78b4d2b30c5 one cycle later with rd_err=0.
- Reverse read (RKS_DECRYPT_EN defined), after the AES-128 fill:
  - Stimulus: rd_idx=0 with rd_dir=1.
  - Required: returns 13111d7fe3944a17...; the same read with the macro undefined returns 000102...0f.
- AES-256 fill and errors:
  - Stimulus: start with keyLen=1, 15 keys, then read idx 14 and idx 15.
  - Required: idx 14 returns the 15th key; idx 15 gives rd_err=1 and rd_key=0.
- Partial fill:
  - Stimulus: 3 keys written, then read idx 2 and idx 3.
  - Required: idx 2 is legal; idx 3 errors; a 4th key and a read of idx 3 in the same cycle still errors.
- Overflow and restart:
  - Stimulus: a 12th key after an AES-128 fill, then start.
  - Required: ovf=1 and fill_cnt stays 11; start with a simultaneous key_valid clears ovf and gives fill_cnt=0 with nothing written.
- Reset mid-fill:
  - Stimulus: reset low after 5 writes.
  - Required: all outputs 0 immediately, reads error, keys without start set ovf.
